// File: rtl/trace_check_ctrl_if.sv
// ----------------------------------------------------------------------------
// trace_check_ctrl_if
//   Bundles the CPU write-back debug port and the golden trace ROM port seen
//   by trace_check_ctrl.
//
//   master : environment side (CPU debug port + golden ROM model)
//   slave  : the trace checker
//
//   Signals
//     debug_wb_pc        32  PC of retiring instruction        (master -> slave)
//     debug_wb_rf_wen     1  write-back valid this cycle        (master -> slave)
//     debug_wb_rf_addr    5  destination register               (master -> slave)
//     debug_wb_rf_wdata  32  write-back data                    (master -> slave)
//     cpu_stall           1  hold write-back stage request      (slave -> master)
//     ref_rd_en           1  ROM read strobe                    (slave -> master)
//     ref_addr           AW  ROM index                          (slave -> master)
//     ref_rd_data        72  ROM data, valid one cycle after ref_rd_en
//
//   Handshake: a write-back is transferred on every rising edge where
//   debug_wb_rf_wen is high; there is no ready. cpu_stall is advisory and
//   leaves room for exactly one more write-back after it rises. The ROM
//   answers a ref_rd_en strobe with ref_rd_data exactly one cycle later.
// ----------------------------------------------------------------------------
interface trace_check_ctrl_if #(
    parameter int AW = 10
);
    logic [31:0]   debug_wb_pc;
    logic          debug_wb_rf_wen;
    logic [4:0]    debug_wb_rf_addr;
    logic [31:0]   debug_wb_rf_wdata;
    logic          cpu_stall;
    logic          ref_rd_en;
    logic [AW-1:0] ref_addr;
    logic [71:0]   ref_rd_data;

    modport master (
        output debug_wb_pc,
        output debug_wb_rf_wen,
        output debug_wb_rf_addr,
        output debug_wb_rf_wdata,
        input  cpu_stall,
        input  ref_rd_en,
        input  ref_addr,
        output ref_rd_data
    );

    modport slave (
        input  debug_wb_pc,
        input  debug_wb_rf_wen,
        input  debug_wb_rf_addr,
        input  debug_wb_rf_wdata,
        output cpu_stall,
        output ref_rd_en,
        output ref_addr,
        input  ref_rd_data
    );
endinterface

// File: rtl/trace_check_ctrl.sv
// ----------------------------------------------------------------------------
// trace_check_ctrl
//   Write-back trace checker. Every register write-back (r0 excluded) from
//   the CPU debug port is queued in a small FIFO; a FETCH/WAIT/READY loop reads
//   the golden trace ROM in order and compares each entry with the FIFO head.
//   The verdict is shown on test_pass/test_err/err_code/leds.
//
//   Ports
//     clk          in   sole clock, rising edge
//     reset        in   synchronous active-high reset
//     bus          slave modport of trace_check_ctrl_if (CPU debug + ROM)
//     test_pass    out  sticky pass
//     test_err     out  sticky fail
//     err_code     out  0 none, 1 mismatch, 2 overflow, 3 length error
//     match_count  out  number of entries compared equal
//     leds         out  FFFF running, 0000 pass, {3FFF, err_code} fail
//     debug_state  out  current FSM state encoding
// ----------------------------------------------------------------------------
module trace_check_ctrl #(
    parameter int          TRACE_DEPTH = 1024,
    parameter logic [31:0] FINAL_PC    = 32'hBFC0_0100,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    trace_check_ctrl_if.slave   bus,
    output logic                test_pass,
    output logic                test_err,
    output logic [1:0]          err_code,
    output logic [31:0]         match_count,
    output logic [15:0]         leds,
    output logic [2:0]          debug_state
);

    localparam int AW = $clog2(TRACE_DEPTH);
    // idx must be able to hold TRACE_DEPTH itself, hence one extra bit
    localparam int IW = AW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    // FIFO / compare entry: {pc[31:0], addr[4:0], wdata[31:0]}
    localparam int EW = 69;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WAIT  = 3'd1,
        S_READY = 3'd2,
        S_DRAIN = 3'd3,
        S_PASS  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            final_seen;
    logic [EW-1:0]   ref_q;
    logic [1:0]      fail_code;

    logic            running;
    logic            push;
    logic            pop;
    logic            fifo_we;
    logic            overflow;
    logic            fifo_empty;
    logic            fifo_full;
    logic [EW-1:0]   head;
    logic [EW-1:0]   push_entry;

    assign running    = (state != S_PASS) && (state != S_FAIL);
    assign push       = running && bus.debug_wb_rf_wen && (bus.debug_wb_rf_addr != 5'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];
    assign push_entry = {bus.debug_wb_pc, bus.debug_wb_rf_addr, bus.debug_wb_rf_wdata};
    // A push into a full FIFO is only accepted when the head leaves the same cycle
    assign overflow   = push && fifo_full && !pop;
    assign fifo_we    = push && (!fifo_full || pop);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, pop decision and failure cause
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fail_code = 2'd0;
        case (state)
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_READY;
            S_READY: begin
                if (!fifo_empty) begin
                    if (head == ref_q) begin
                        pop       = 1'b1;
                        state_nxt = (idx == IW'(TRACE_DEPTH - 1)) ? S_DRAIN : S_FETCH;
                    end else begin
                        state_nxt = S_FAIL;
                        fail_code = 2'd1;
                    end
                end else if (final_seen) begin
                    // program ended before the golden trace was used up
                    state_nxt = S_FAIL;
                    fail_code = 2'd3;
                end
            end
            S_DRAIN: begin
                if (!fifo_empty) begin
                    // CPU produced more write-backs than the golden trace holds
                    state_nxt = S_FAIL;
                    fail_code = 2'd3;
                end else if (final_seen) begin
                    state_nxt = S_PASS;
                end
            end
            default: ;
        endcase
        // overflow outranks any compare result in the same cycle
        if (overflow) begin
            state_nxt = S_FAIL;
            fail_code = 2'd2;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        test_pass     = (state == S_PASS);
        test_err      = (state == S_FAIL);
        bus.ref_rd_en = (state == S_FETCH) && !reset;
        bus.ref_addr  = idx[AW-1:0];
        // two or fewer... i.e. at most one free slot left: the CPU may still
        // deliver one write-back after seeing the stall
        bus.cpu_stall = running && !reset && (count >= CW'(FIFO_DEPTH - 1));
        debug_state   = state;
        case (state)
            S_PASS:  leds = 16'h0000;
            S_FAIL:  leds = {14'h3FFF, err_code};
            default: leds = 16'hFFFF;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: FIFO pointers, golden index, counters, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            idx         <= '0;
            final_seen  <= 1'b0;
            ref_q       <= '0;
            err_code    <= 2'd0;
            match_count <= 32'd0;
        end else begin
            if (bus.debug_wb_pc == FINAL_PC) begin
                final_seen <= 1'b1;
            end
            if (fifo_we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                idx         <= idx + IW'(1);
                match_count <= match_count + 32'd1;
            end
            case ({fifo_we, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (state == S_WAIT) begin
                ref_q <= {bus.ref_rd_data[71:40], bus.ref_rd_data[36:32], bus.ref_rd_data[31:0]};
            end
            if ((state_nxt == S_FAIL) && (state != S_FAIL)) begin
                err_code <= fail_code;
            end
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: doc/trace_check_ctrl.md
# trace_check_ctrl

Synthesizable write-back trace checker/scheduler sitting beside `CPU` at top level. Captures every architectural register write-back from the CPU debug port into a small FIFO, sequences reads of a golden trace ROM (72-bit entries: pc[71:40], addr[36:32], wdata[31:0]), compares entries in order and reports PASS/FAIL on LEDs. Applies back-pressure to the CPU when the compare pipeline falls behind.

## Interface
- `TRACE_DEPTH`, 1024: number of golden entries; ROM address width `AW = $clog2(TRACE_DEPTH)`.
- `FINAL_PC`, 32'hBFC0_0100: PC whose write-back marks end of test.
- `FIFO_DEPTH`, 8: pending write-back slots (power of two, ≥4).

- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `debug_wb_pc`  in  32  PC of retiring instruction.
- `debug_wb_rf_wen`  in  1  write-back valid this cycle.
- `debug_wb_rf_addr`  in  5  destination register.
- `debug_wb_rf_wdata`  in  32  write-back data.
- `cpu_stall`  out  1  request CPU to hold write-back stage.
- `ref_rd_en`  out  1  ROM read strobe.
- `ref_addr`  out  AW  ROM index.
- `ref_rd_data`  in  72  ROM data, valid exactly one cycle after `ref_rd_en`.
- `test_pass`  out  1  sticky pass.
- `test_err`  out  1  sticky fail.
- `err_code`  out  2  0 none, 1 mismatch, 2 overflow, 3 length error.
- `match_count`  out  32  entries compared equal.
- `leds`  out  16  status display.

## Operation
- Push: cycle with `debug_wb_rf_wen && debug_wb_rf_addr != 0` pushes {pc, addr, wdata} into FIFO. Writes to r0 never pushed.
- Final detect: `final_seen` latches when `debug_wb_pc == FINAL_PC` on any cycle with `debug_wb_rf_wen` asserted or not; sticky.
- FSM states: FETCH, WAIT, READY, DRAIN, PASS, FAIL.
  - FETCH: `ref_rd_en=1`, `ref_addr=idx`; -> WAIT.
  - WAIT: capture `ref_rd_data` into `ref_q`; -> READY.
  - READY: if FIFO non-empty, compare head to `ref_q` (pc, addr, wdata all equal). Match: pop, `idx++`, `match_count++`; -> FETCH if new idx < TRACE_DEPTH, else DRAIN. Mismatch: -> FAIL, err_code 1. FIFO empty: hold.
  - DRAIN (golden exhausted): any FIFO non-empty -> FAIL, err_code 3; `final_seen && FIFO empty` -> PASS.
  - READY with `final_seen`, FIFO empty, idx < TRACE_DEPTH -> FAIL, err_code 3 (trace too short).
  - PASS/FAIL terminal until `reset`.
- Overflow: push while FIFO full -> FAIL, err_code 2 (priority over mismatch in same cycle).
- `cpu_stall` = free slots ≤ 1 and state not PASS/FAIL; CPU may still deliver one write-back after assertion.
- In PASS/FAIL pushes ignored, `ref_rd_en=0`.
- `leds`: 16'hFFFF running, 16'h0000 PASS, {14'h3FFF, err_code} on FAIL (e.g. mismatch 16'hFFFD).

## Timing
- Reset values: state FETCH, idx 0, FIFO empty, `final_seen` 0, `test_pass` 0, `test_err` 0, `err_code` 0, `match_count` 0, `leds` 16'hFFFF, `cpu_stall` 0, `ref_rd_en` 0 during reset cycle.
- First ROM read issued cycle after `reset` deasserts.
- Compare throughput: one entry per 3 cycles (FETCH, WAIT, READY); push-to-compare latency ≥ 2 cycles, FIFO absorbs bursts.
- Simultaneous push and pop same cycle: both occur, occupancy unchanged; push when full and pop same cycle is not overflow.
- `final_seen` same cycle as its own push: entry still compared before PASS.
- `test_pass`/`test_err`/`leds` update cycle after deciding compare/condition; never both set.
- `reset` mid-run: any state returns to reset values next edge, in-flight ROM data discarded.

## Test plan
- TRACE_DEPTH=4, four matching writes (pc 0x..00,04,08,0C) then pc FINAL_PC -> `test_pass`=1, `leds`=16'h0000, `match_count`=4.
- Entry 2 wdata 0x12345678 vs golden 0x12345679 -> FAIL, err_code 1, `leds`=16'hFFFD, `match_count`=2.
- Write-backs every cycle for 20 cycles, CPU ignoring `cpu_stall` -> overflow FAIL err_code 2; honoring stall -> no error, all matched.
- Write to r0 interleaved between golden writes -> ignored, PASS.
- FINAL_PC reached after 3 of 4 entries -> FAIL err_code 3; 5th extra write after 4 matched -> FAIL err_code 3.
- Assert `reset` one cycle while in WAIT with FIFO holding 3 entries -> all outputs at reset values, rerun passes.
